count_capture: RTL and testbench

//  Downstream consumer of the 4-bit ripple counter. Brings the asynchronous,

---
 rtl/count_capture_pkg.sv | 12 +
 rtl/count_capture_if.sv | 11 +
 rtl/count_capture_sync_ff.sv | 25 ++
 rtl/count_capture.sv | 130 +++++++++++++
 tb/tb_count_capture.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/count_capture_pkg.sv
// Shared definitions for the ripple-counter capture path: FSM states and default widths.
package count_capture_pkg;

  localparam int unsigned CntWDef = 4;
  localparam int unsigned ExtWDef = 16;

  typedef enum logic {
    StTrack,
    StSettle
  } state_e;

endpackage

// File: rtl/count_capture_if.sv
// Valid/ready record channel carrying the extended count downstream.
interface count_capture_if #(
  parameter int unsigned EXT_W = 16
);
  logic             out_valid;
  logic             out_ready;
  logic [EXT_W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/count_capture_sync_ff.sv
// Plain N-flop synchronizer with synchronous active-high reset to zero.
module count_capture_sync_ff #(
  parameter int unsigned W      = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [STAGES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(STAGES); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < int'(STAGES); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/count_capture.sv
// Captures an asynchronous ripple-counter value, rejects ripple transients, extends it
// across wrap-around and offers each new extended count on a valid/ready channel.
module count_capture
  import count_capture_pkg::*;
#(
  parameter int unsigned CNT_W         = CntWDef,
  parameter int unsigned EXT_W         = ExtWDef,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] q_in,
  count_capture_if.master  out_if,
  output logic             wrap_pulse,
  output logic             overrun,
  output logic             ext_ovf
);

  localparam int unsigned StabW = $clog2(STABLE_CYCLES) + 1;

  logic [CNT_W-1:0] s_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] acc_q, acc_d, cand_q, cand_d;
  logic [StabW-1:0] stab_q, stab_d;
  logic [EXT_W-1:0] ext_q, ext_d, data_q, data_d;
  logic             valid_q, valid_d, wrap_q, wrap_d, ovr_q, ovr_d, eovf_q, eovf_d;
  logic             commit;
  logic [CNT_W-1:0] delta;
  logic [EXT_W:0]   sum;

  count_capture_sync_ff #(
    .W      (CNT_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (q_in),
    .q_o   (s_q)
  );

  // Glitch filter: a new code must repeat STABLE_CYCLES times before it is accepted.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    stab_d  = stab_q;
    commit  = 1'b0;
    unique case (state_q)
      StTrack: begin
        if (s_q != acc_q) begin
          cand_d  = s_q;
          stab_d  = StabW'(1);
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (s_q == acc_q) begin
          state_d = StTrack;
        end else if (s_q != cand_q) begin
          cand_d = s_q;
          stab_d = StabW'(1);
        end else if (stab_q < StabW'(STABLE_CYCLES - 1)) begin
          stab_d = stab_q + StabW'(1);
        end else begin
          commit  = 1'b1;
          state_d = StTrack;
        end
      end
      default: state_d = StTrack;
    endcase
  end

  // Modular difference covers multi-count jumps between commits.
  assign delta = cand_q - acc_q;
  assign sum   = {1'b0, ext_q} + {{(EXT_W + 1 - CNT_W){1'b0}}, delta};

  always_comb begin
    acc_d   = acc_q;
    ext_d   = ext_q;
    data_d  = data_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    ovr_d   = ovr_q;
    eovf_d  = eovf_q;
    if (commit) begin
      acc_d   = cand_q;
      ext_d   = sum[EXT_W-1:0];
      data_d  = sum[EXT_W-1:0];
      valid_d = 1'b1;
      wrap_d  = (cand_q < acc_q);
      if (sum[EXT_W]) eovf_d = 1'b1;
      if (valid_q && !out_if.out_ready) ovr_d = 1'b1;
    end else if (valid_q && out_if.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StTrack;
      acc_q   <= '0;
      cand_q  <= '0;
      stab_q  <= '0;
      ext_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      ovr_q   <= 1'b0;
      eovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cand_q  <= cand_d;
      stab_q  <= stab_d;
      ext_q   <= ext_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      ovr_q   <= ovr_d;
      eovf_q  <= eovf_d;
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign wrap_pulse       = wrap_q;
  assign overrun          = ovr_q;
  assign ext_ovf          = eovf_q;

endmodule

// File: tb/tb_count_capture.sv
// Directed bench for count_capture with a run-length reference model checked every cycle.
module tb_count_capture;

  localparam int SyncStages   = 2;
  localparam int StableCycles = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] q_in = 4'd0;
  logic       wrap_pulse, overrun, ext_ovf;

  count_capture_if #(.EXT_W(16)) bus ();

  count_capture dut (
    .clk        (clk),
    .reset      (reset),
    .q_in       (q_in),
    .out_if     (bus.master),
    .wrap_pulse (wrap_pulse),
    .overrun    (overrun),
    .ext_ovf    (ext_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: s_q is q_in delayed by SyncStages samples; a value is accepted once
  // it has been seen StableCycles times in a row while differing from the accepted value.
  int  qh[$];
  int  m_acc, m_run_val, m_run_len, m_ext;
  bit  m_started = 0;
  bit  m_valid, m_wrap, m_ovr, m_eovf;
  int  m_data;

  always @(posedge clk) begin
    int s, d;
    if (reset) begin
      qh.delete();
      for (int i = 0; i < SyncStages; i++) qh.push_back(0);
      m_acc = 0; m_run_val = 0; m_run_len = 0; m_ext = 0;
      m_valid = 0; m_wrap = 0; m_ovr = 0; m_eovf = 0; m_data = 0;
      m_started = 1;
    end else if (m_started) begin
      s = qh.pop_front();
      qh.push_back(int'(q_in));
      m_wrap = 0;
      if (s != m_acc) begin
        if (m_run_len > 0 && s == m_run_val) m_run_len++;
        else begin
          m_run_val = s;
          m_run_len = 1;
        end
      end else begin
        m_run_len = 0;
      end
      if (m_run_len == StableCycles) begin
        d = (s - m_acc + 16) % 16;
        if (m_valid && !bus.out_ready) m_ovr = 1;
        m_wrap  = (s < m_acc);
        m_ext   = m_ext + d;
        if (m_ext >= 65536) begin
          m_eovf = 1;
          m_ext  = m_ext - 65536;
        end
        m_data    = m_ext;
        m_valid   = 1;
        m_acc     = s;
        m_run_len = 0;
      end else if (m_valid && bus.out_ready) begin
        m_valid = 0;
      end
    end
  end

  int wrap_seen = 0;

  always @(negedge clk) begin
    if (m_started) begin
      chk("out_valid", int'(bus.out_valid), int'(m_valid));
      chk("out_data", int'(bus.out_data), m_data);
      chk("wrap_pulse", int'(wrap_pulse), int'(m_wrap));
      chk("overrun", int'(overrun), int'(m_ovr));
      chk("ext_ovf", int'(ext_ovf), int'(m_eovf));
      if (wrap_pulse) wrap_seen++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    q_in  = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int v;
    int exp_seq[3];
    int step_val[3];
    bus.out_ready = 1'b1;

    // 1: reset, idle
    do_reset();
    wait_cyc(20);
    chk("t1_valid", int'(bus.out_valid), 0);
    chk("t1_data", int'(bus.out_data), 0);
    chk("t1_flags", int'({wrap_pulse, overrun, ext_ovf}), 0);

    // 2: single step, commit at edge 3
    q_in = 4'd1;
    wait_cyc(3);
    chk("t2_early_valid", int'(bus.out_valid), 0);
    wait_cyc(1);
    chk("t2_valid", int'(bus.out_valid), 1);
    chk("t2_data", int'(bus.out_data), 1);
    wait_cyc(1);
    chk("t2_single_beat", int'(bus.out_valid), 0);

    // 3: one-cycle glitch is rejected
    q_in = 4'd3;
    wait_cyc(1);
    q_in = 4'd1;
    for (int i = 0; i < 8; i++) chk_glitch: begin
      wait_cyc(1);
      chk("t3_no_valid", int'(bus.out_valid), 0);
    end
    chk("t3_data_kept", int'(bus.out_data), 1);

    // 4: wrap across 15 -> 0
    do_reset();
    q_in = 4'd14;
    wait_cyc(6);
    chk("t4_base", int'(bus.out_data), 14);
    wrap_seen = 0;
    step_val = '{15, 0, 1};
    exp_seq  = '{15, 16, 17};
    for (int i = 0; i < 3; i++) begin
      q_in = 4'(step_val[i]);
      wait_cyc(4);
      chk("t4_valid", int'(bus.out_valid), 1);
      chk("t4_data", int'(bus.out_data), exp_seq[i]);
      wait_cyc(2);
    end
    chk("t4_wrap_count", wrap_seen, 1);

    // 5: overrun while stalled
    bus.out_ready = 1'b0;
    do_reset();
    q_in = 4'd1;
    wait_cyc(6);
    q_in = 4'd2;
    wait_cyc(6);
    chk("t5_data", int'(bus.out_data), 2);
    chk("t5_overrun", int'(overrun), 1);
    chk("t5_valid", int'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    wait_cyc(1);
    chk("t5_one_transfer", int'(bus.out_valid), 0);
    chk("t5_overrun_sticky", int'(overrun), 1);

    // 6: reset during SETTLE with a pending record
    bus.out_ready = 1'b0;
    q_in = 4'd3;
    wait_cyc(6);
    chk("t6_pending", int'(bus.out_valid), 1);
    q_in = 4'd4;
    wait_cyc(3);
    reset = 1'b1;
    q_in  = 4'd0;
    wait_cyc(1);
    chk("t6_valid", int'(bus.out_valid), 0);
    chk("t6_data", int'(bus.out_data), 0);
    chk("t6_flags", int'({wrap_pulse, overrun, ext_ovf}), 0);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    wait_cyc(8);
    chk("t6_acc_zero", int'(bus.out_valid), 0);
    q_in = 4'd1;
    wait_cyc(4);
    chk("t6_after_data", int'(bus.out_data), 1);

    // 7: extended counter overflow via jumps of 15
    do_reset();
    v = 0;
    for (int i = 0; i < 4370; i++) begin
      if (i == 4369) chk("t7_no_ovf_yet", int'(ext_ovf), 0);
      v = (v + 15) % 16;
      q_in = 4'(v);
      wait_cyc(5);
    end
    chk("t7_ovf", int'(ext_ovf), 1);
    chk("t7_data", int'(bus.out_data), 14);
    chk("t7_model_ext", m_ext, 14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
